// File: rtl/spi_cmd_parser_if.sv
// spi_cmd_parser_if: SPI pins plus the parameter/strobe bus that spi_cmd_parser
// exposes to the discharge state machine. The master side is the host plus the
// machine; the slave side is the parser itself.
interface spi_cmd_parser_if;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        machining_active;
   logic [15:0] ton_us;
   logic [15:0] toff_us;
   logic [15:0] ip_set;
   logic [7:0]  mode;
   logic        param_update;
   logic        start_pulse;
   logic        stop_pulse;
   logic        err_sticky;

   modport master (
      output sclk, cs_n, mosi, machining_active,
      input  miso, ton_us, toff_us, ip_set, mode, param_update, start_pulse, stop_pulse,
             err_sticky
   );

   modport slave (
      input  sclk, cs_n, mosi, machining_active,
      output miso, ton_us, toff_us, ip_set, mode, param_update, start_pulse, stop_pulse,
             err_sticky
   );
endinterface

// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: synchronizes the host SPI stream, assembles MSB-first bytes and
// decodes them into EDM pulse parameters (Ton, Toff, Ip, mode) plus start/stop strobes.
// Optional status readback on miso is built only when SPI_STATUS_READBACK_EN is defined;
// otherwise miso is tied low.
module spi_cmd_parser #(
   parameter int unsigned TON_RST      = 100,
   parameter int unsigned TOFF_RST     = 50,
   parameter int unsigned IP_RST       = 0,
   parameter int unsigned IP_MAX       = 120,
   parameter int unsigned BYTE_TIMEOUT = 2_000_000
) (
   input logic            clk_in,
   input logic            sys_rst_n,
   spi_cmd_parser_if.slave bus
);

   localparam int unsigned TmoW = $clog2(BYTE_TIMEOUT + 1);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StGetLo  = 2'd1,
      StGetHi  = 2'd2,
      StCommit = 2'd3
   } state_e;

   // Sync pipelines: [0] metastable stage, [1] synchronized, [2] previous (edge detect)
   logic [2:0] sclk_q, sclk_d;
   logic [2:0] cs_q, cs_d;
   logic [1:0] mosi_q, mosi_d;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] byte_q, byte_d;
   logic       byte_vld_q, byte_vld_d;

   state_e          state_q, state_d;
   logic [7:0]      header_q, header_d;
   logic [7:0]      lo_q, lo_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [15:0]     ton_q, ton_d;
   logic [15:0]     toff_q, toff_d;
   logic [15:0]     ip_q, ip_d;
   logic [7:0]      mode_q, mode_d;
   logic            upd_q, upd_d;
   logic            start_q, start_d;
   logic            stop_q, stop_d;
   logic            err_q, err_d;

   logic        sclk_rise;
   logic        cs_fall;
   logic        cs_rise;
   logic [15:0] value;
   logic        tmo_hit;

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   // Final byte is still in byte_q when GET_HI decodes, so commit happens at D+2
   assign value     = {byte_q, lo_q};
   assign tmo_hit   = (tmo_q == TmoW'(BYTE_TIMEOUT - 1));

   // Synchronizer shift and byte assembly next-state
   always_comb begin
      sclk_d     = {sclk_q[1:0], bus.sclk};
      cs_d       = {cs_q[1:0], bus.cs_n};
      mosi_d     = {mosi_q[0], bus.mosi};
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte_d     = byte_q;
      byte_vld_d = 1'b0;
      if (cs_fall) begin
         bit_cnt_d = 3'd0;
      end else if (sclk_rise && !cs_q[2]) begin
         // Gate on the previous cs so a rise coinciding with cs release still counts
         shift_d   = {shift_q[5:0], mosi_q[1]};
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_vld_d = 1'b1;
            byte_d     = {shift_q, mosi_q[1]};
         end
      end
      if (cs_rise) begin
         bit_cnt_d = 3'd0;
      end
   end

   // Synchronizer and byte assembly registers
   always_ff @(posedge clk_in) begin
      if (!sys_rst_n) begin
         sclk_q     <= 3'b000;
         cs_q       <= 3'b111;
         mosi_q     <= 2'b00;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 7'd0;
         byte_q     <= 8'd0;
         byte_vld_q <= 1'b0;
      end else begin
         sclk_q     <= sclk_d;
         cs_q       <= cs_d;
         mosi_q     <= mosi_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte_q     <= byte_d;
         byte_vld_q <= byte_vld_d;
      end
   end

   // Parser next-state: command decode, commit checks, inter-byte timeout
   always_comb begin
      state_d  = state_q;
      header_d = header_q;
      lo_d     = lo_q;
      tmo_d    = tmo_q;
      ton_d    = ton_q;
      toff_d   = toff_q;
      ip_d     = ip_q;
      mode_d   = mode_q;
      upd_d    = 1'b0;
      start_d  = 1'b0;
      stop_d   = 1'b0;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (byte_vld_q) begin
               if (byte_q[7:4] == 4'h9) begin
                  header_d = byte_q;
                  tmo_d    = '0;
                  state_d  = StGetLo;
               end else begin
                  case (byte_q)
                     8'h06:   start_d = 1'b1;
                     8'h07:   stop_d  = 1'b1;
                     8'h05:   err_d   = 1'b0;
                     default: err_d   = 1'b1;
                  endcase
               end
            end
         end
         StGetLo: begin
            if (byte_vld_q) begin
               lo_d    = byte_q;
               tmo_d   = '0;
               state_d = StGetHi;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StGetHi: begin
            if (byte_vld_q) begin
               state_d = StCommit;
               case (header_q)
                  8'h91: begin
                     if (value != 16'd0) begin
                        ton_d = value;
                        upd_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  8'h9E: begin
                     if (value != 16'd0) begin
                        toff_d = value;
                        upd_d  = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  8'h93: begin
                     if (value <= 16'(IP_MAX)) begin
                        ip_d  = value;
                        upd_d = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  8'h9C: begin
                     if (!bus.machining_active) begin
                        mode_d = lo_q;
                        upd_d  = 1'b1;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  default: err_d = 1'b1;
               endcase
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Parser FSM and registered outputs
   always_ff @(posedge clk_in) begin
      if (!sys_rst_n) begin
         state_q  <= StIdle;
         header_q <= 8'd0;
         lo_q     <= 8'd0;
         tmo_q    <= '0;
         ton_q    <= 16'(TON_RST);
         toff_q   <= 16'(TOFF_RST);
         ip_q     <= 16'(IP_RST);
         mode_q   <= 8'd0;
         upd_q    <= 1'b0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         header_q <= header_d;
         lo_q     <= lo_d;
         tmo_q    <= tmo_d;
         ton_q    <= ton_d;
         toff_q   <= toff_d;
         ip_q     <= ip_d;
         mode_q   <= mode_d;
         upd_q    <= upd_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         err_q    <= err_d;
      end
   end

   assign bus.ton_us       = ton_q;
   assign bus.toff_us      = toff_q;
   assign bus.ip_set       = ip_q;
   assign bus.mode         = mode_q;
   assign bus.param_update = upd_q;
   assign bus.start_pulse  = start_q;
   assign bus.stop_pulse   = stop_q;
   assign bus.err_sticky   = err_q;

`ifdef SPI_STATUS_READBACK_EN
   logic       sclk_fall;
   logic [7:0] rb_q, rb_d;
   logic       miso_q, miso_d;

   assign sclk_fall = ~sclk_q[1] & sclk_q[2];

   // Status shift register: load at frame start, shift on sclk fall, clear at frame end
   always_comb begin
      rb_d = rb_q;
      if (cs_fall) begin
         rb_d = {bus.machining_active, err_q, state_q, header_q[3:0]};
      end else if (cs_rise) begin
         rb_d = 8'd0;
      end else if (sclk_fall && !cs_q[1]) begin
         rb_d = {rb_q[6:0], 1'b0};
      end
      miso_d = cs_q[1] ? 1'b0 : rb_q[7];
   end

   // Readback registers
   always_ff @(posedge clk_in) begin
      if (!sys_rst_n) begin
         rb_q   <= 8'd0;
         miso_q <= 1'b0;
      end else begin
         rb_q   <= rb_d;
         miso_q <= miso_d;
      end
   end

   assign bus.miso = miso_q;
`else
   assign bus.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: directed bench for spi_cmd_parser; drives SPI mode-0 frames and
// checks parameters, strobe counts/timing, error handling, timeout and status readback.
module tb_spi_cmd_parser;

   localparam int unsigned Tmo = 300;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   n_start = 0;
   int   n_stop = 0;
   int   n_upd = 0;
   int   start_cyc = 0;
   int   stop_cyc = 0;
   int   last_rise_cyc = 0;
   logic [7:0] rx;

   spi_cmd_parser_if bus_if ();

   spi_cmd_parser #(
      .TON_RST      (100),
      .TOFF_RST     (50),
      .IP_RST       (0),
      .IP_MAX       (120),
      .BYTE_TIMEOUT (Tmo)
   ) dut (
      .clk_in    (clk),
      .sys_rst_n (rst_n),
      .bus       (bus_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.start_pulse) begin
            n_start++;
            start_cyc = cyc;
         end
         if (bus_if.stop_pulse) begin
            n_stop++;
            stop_cyc = cyc;
         end
         if (bus_if.param_update) n_upd++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cs_n frame carrying the first nbits of b, MSB first; miso captured at each rise
   task automatic spi_frame(input logic [7:0] b, input int nbits);
      bus_if.cs_n = 1'b0;
      rx = 8'd0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bus_if.mosi = b[7-i];
         repeat (4) @(negedge clk);
         rx = {rx[6:0], bus_if.miso};
         bus_if.sclk = 1'b1;
         last_rise_cyc = cyc;
         repeat (4) @(negedge clk);
         bus_if.sclk = 1'b0;
      end
      repeat (4) @(negedge clk);
      bus_if.cs_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic cmd3(input logic [7:0] h, input logic [7:0] lo, input logic [7:0] hi);
      spi_frame(h, 8);
      spi_frame(lo, 8);
      spi_frame(hi, 8);
   endtask

   initial begin
      bus_if.cs_n = 1'b1;
      bus_if.sclk = 1'b0;
      bus_if.mosi = 1'b0;
      bus_if.machining_active = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_ton", 32'(bus_if.ton_us), 100);
      chk("rst_toff", 32'(bus_if.toff_us), 50);
      chk("rst_ip", 32'(bus_if.ip_set), 0);
      chk("rst_mode", 32'(bus_if.mode), 0);
      chk("rst_err", 32'(bus_if.err_sticky), 0);
      chk("rst_miso", 32'(bus_if.miso), 0);
      chk("rst_strobes", 32'({bus_if.start_pulse, bus_if.stop_pulse, bus_if.param_update}), 0);

      cmd3(8'h91, 8'h64, 8'h00);
      chk("ton_100", 32'(bus_if.ton_us), 100);
      chk("upd_1", 32'(n_upd), 1);
      chk("err_0a", 32'(bus_if.err_sticky), 0);

      cmd3(8'h91, 8'h2C, 8'h01);
      chk("ton_300", 32'(bus_if.ton_us), 300);

      cmd3(8'h9E, 8'h32, 8'h00);
      cmd3(8'h93, 8'h3C, 8'h00);
      cmd3(8'h9C, 8'h00, 8'h00);
      chk("toff_50", 32'(bus_if.toff_us), 50);
      chk("ip_60", 32'(bus_if.ip_set), 60);
      chk("mode_0", 32'(bus_if.mode), 0);
      chk("upd_5", 32'(n_upd), 5);

      cmd3(8'h9C, 8'h05, 8'h00);
      chk("mode_5", 32'(bus_if.mode), 5);
      bus_if.machining_active = 1'b1;
      cmd3(8'h9C, 8'h07, 8'h00);
      chk("mode_locked", 32'(bus_if.mode), 5);
      chk("mode_locked_err", 32'(bus_if.err_sticky), 1);
      chk("mode_locked_upd", 32'(n_upd), 6);
      bus_if.machining_active = 1'b0;
      spi_frame(8'h05, 8);
      chk("err_clr1", 32'(bus_if.err_sticky), 0);

      spi_frame(8'h06, 8);
      chk("start_cnt1", 32'(n_start), 1);
      chk("start_lat", 32'(start_cyc - last_rise_cyc), 4);
      spi_frame(8'h07, 8);
      chk("stop_cnt1", 32'(n_stop), 1);
      chk("stop_lat", 32'(stop_cyc - last_rise_cyc), 4);
      chk("start_cnt_still1", 32'(n_start), 1);

      cmd3(8'h91, 8'h00, 8'h00);
      chk("ton_zero_rej", 32'(bus_if.ton_us), 300);
      chk("ton_zero_err", 32'(bus_if.err_sticky), 1);
      spi_frame(8'h05, 8);
      chk("err_clr2", 32'(bus_if.err_sticky), 0);
      cmd3(8'h93, 8'h79, 8'h00);
      chk("ip_121_rej", 32'(bus_if.ip_set), 60);
      chk("ip_121_err", 32'(bus_if.err_sticky), 1);
      spi_frame(8'h05, 8);
      cmd3(8'h93, 8'h78, 8'h00);
      chk("ip_120_ok", 32'(bus_if.ip_set), 120);
      chk("ip_120_err", 32'(bus_if.err_sticky), 0);
      chk("upd_7", 32'(n_upd), 7);

      cmd3(8'h95, 8'h01, 8'h00);
      chk("unk_hdr_err", 32'(bus_if.err_sticky), 1);
      chk("unk_hdr_upd", 32'(n_upd), 7);
      spi_frame(8'h05, 8);
      chk("err_clr3", 32'(bus_if.err_sticky), 0);

      spi_frame(8'h91, 8);
      spi_frame(8'h64, 8);
      repeat (Tmo + 100) @(negedge clk);
      chk("tmo_err", 32'(bus_if.err_sticky), 1);
      chk("tmo_ton", 32'(bus_if.ton_us), 300);
      spi_frame(8'h06, 8);
      chk("tmo_then_start", 32'(n_start), 2);
      spi_frame(8'h05, 8);

      spi_frame(8'h06, 5);
      chk("partial_err", 32'(bus_if.err_sticky), 0);
      chk("partial_start", 32'(n_start), 2);
      spi_frame(8'h06, 8);
      chk("after_partial", 32'(n_start), 3);

      // Status byte: {active=1, err=0, state=IDLE, header[3:0]=1}
      bus_if.machining_active = 1'b1;
      spi_frame(8'h05, 8);
`ifdef SPI_STATUS_READBACK_EN
      chk("readback", 32'(rx), 32'h81);
`else
      chk("readback", 32'(rx), 32'h00);
`endif
      chk("miso_idle", 32'(bus_if.miso), 0);
      bus_if.machining_active = 1'b0;

      spi_frame(8'h91, 8);
      spi_frame(8'h2C, 8);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      spi_frame(8'h01, 8);
      chk("rst_mid_ton", 32'(bus_if.ton_us), 100);
      chk("rst_mid_ip", 32'(bus_if.ip_set), 0);
      chk("rst_mid_err", 32'(bus_if.err_sticky), 1);
      chk("rst_mid_upd", 32'(n_upd), 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
